loteria_param: RTL and testbench
================================

Name: loteria_param

Overview:
- Parametrised lottery-ticket checker: the player enters an N-digit BCD guess one digit at a time, then finishes, and the block grades the guess against a secret number.
- Generalises the fixed 5-digit game in four ways:
  - configurable digit count;
  - secret reloadable at run time (program mode);
  - digit delete;
  - four prize tiers.
- Insert, delete, finish and prog act on edges, not levels.
- Sits between board switches/keys and the 7-segment/LED display logic.

Parameters:
- N_DIGITS, 5, number of digits per ticket; legal 3..8.
- SECRET_INIT, 32'h0005_0967, reset value of the secret; BCD, low 4*N_DIGITS bits used, digit 0 = most significant entered digit.
- HOLD_CYCLES, 0, cycles RESULT is held before auto-return to ENTRY; 0 = hold until reset or finish edge.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- num  in  4  digit value from switches.
- insert  in  1  level; rising edge = store num.
- del  in  1  level; rising edge = delete last digit.
- finish  in  1  level; rising edge = submit (READY) / new game (RESULT).
- prog  in  1  level; rising edge = enter program-secret mode.
- state  out  3  0=ENTRY 1=READY 2=CHECK 3=RESULT 4=PROG.
- count  out  4  digits currently entered, 0..N_DIGITS.
- digits  out  4*N_DIGITS  entered digits, digit i at [4i+3:4i]; unentered slots = 0.
- hex  out  7*N_DIGITS  active-low 7-seg per digit slot; unentered or PROG slot shows "-" (7'b0111111).
- prize  out  2  0 none, 1 small, 2 medium, 3 jackpot.
- win  out  1  prize != 0, valid in RESULT.
- err  out  1  one-cycle pulse on a rejected action.

Behaviour:
- Edge detection:
  - Each of insert/del/finish/prog is registered once; edge = in & ~in_q.
  - The action is taken on the same clock edge the edge is detected.
  - The *_q registers are also cleared by reset.
- Priority when several edges arrive in one cycle: prog > del > insert > finish. Only one action is taken; the others are ignored (no err).
- Reset, from any state including mid-entry or PROG:
  - state=ENTRY, count=0, digits=0, prize=0, win=0, err=0.
  - secret reloads SECRET_INIT (a programmed secret is lost).
- ENTRY:
  - insert edge with num<=9: store num at slot count, count+1. If count reaches N_DIGITS, go to READY.
  - insert edge with num>9: err pulse, nothing stored.
  - del edge with count>0: count-1, vacated slot cleared to 0.
  - del edge with count==0: err.
  - finish edge: err (ticket incomplete).
  - prog edge with count==0: go to PROG. With count>0: err.
- READY:
  - finish edge: go to CHECK.
  - del edge: count-1, return to ENTRY.
  - insert edge: err.
- CHECK (exactly 1 cycle, then RESULT):
  - H = number of positions i where digit_i == secret_i.
  - L = (digit_{N-1} == secret_{N-1}).
  - Tiers, first match wins:
    - H==N gives prize 3.
    - H==N-1 gives prize 2.
    - L && H>=N-2 gives prize 1.
    - otherwise 0.
  - prize and win are registered on the CHECK→RESULT edge.
- RESULT:
  - prize, win and digits hold.
  - finish edge, or expiry of HOLD_CYCLES when non-zero: count=0, digits=0, prize=0, win=0, go to ENTRY.
  - Other edges are ignored.
- PROG:
  - Same entry rules as ENTRY, but digits write a shadow register; hex shows "-" for all slots.
  - On the N-th valid digit, shadow is copied to secret, count=0, go to ENTRY.
  - del edge in PROG at count==0: abort, go to ENTRY, secret unchanged.
- The secret is never visible on any output.
- hex and the other outputs are derived from registers; there is no combinational path from the inputs.

Test Plan:
- Default secret, N=5: enter 5,0,9,6,7 then finish → state 0→1→2→3; prize=3, win=1 one cycle after CHECK; hex = 0010010,1000000,0010000,0000010,1111000.
- Enter 5,0,9,6,1 → prize=2. Enter 5,0,1,2,7 → prize=1 (H=3, L=1). Enter 1,2,3,4,7 → prize=0, win=0.
- Enter 5,0,9, then del, then del, then insert 0 → count=2, digits slot1=0, slot2=0. Insert num=12 → err pulse, count unchanged. del at count=0 → err.
- Hold insert high for 10 cycles → exactly one digit stored. Assert insert and del edges in the same cycle → only delete occurs.
- prog edge, enter 1,2,3,4,5 → back to ENTRY; play 1,2,3,4,5 → prize=3. Then reset → play 5,0,9,6,7 → prize=3 (secret restored).
- Reset asserted mid-entry (count=3) and in RESULT → next cycle state=0, count=0, prize=0, win=0. Repeat with N_DIGITS=3 and HOLD_CYCLES=4: RESULT returns to ENTRY after 4 cycles.

Source files
------------

// File: rtl/loteria_param.sv
// Lottery-ticket checker: collects an N-digit BCD guess one digit at a time and
// grades it against a run-time programmable secret into four prize tiers.
module loteria_param #(
  parameter int          N_DIGITS    = 5,
  parameter logic [31:0] SECRET_INIT = 32'h0005_0967,
  parameter int          HOLD_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            num,
  input  logic                  insert,
  input  logic                  del,
  input  logic                  finish,
  input  logic                  prog,
  output logic [2:0]            state,
  output logic [3:0]            count,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [7*N_DIGITS-1:0] hex,
  output logic [1:0]            prize,
  output logic                  win,
  output logic                  err
);

  typedef enum logic [2:0] {
    ST_ENTRY  = 3'd0,
    ST_READY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_RESULT = 3'd3,
    ST_PROG   = 3'd4
  } state_t;

  localparam int          DW        = 4 * N_DIGITS;
  localparam logic [3:0]  N_CNT     = 4'(N_DIGITS);
  localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;

  state_t        r_state, w_state_next;
  logic [3:0]    r_count, w_count_next;
  logic [DW-1:0] r_digits, w_digits_next;
  logic [DW-1:0] r_shadow, w_shadow_next;
  logic [DW-1:0] r_secret, w_secret_next;
  logic [1:0]    r_prize, w_prize_next;
  logic          r_win, w_win_next;
  logic          r_err, w_err_next;
  logic [31:0]   r_hold, w_hold_next;
  logic          r_ins_q, r_del_q, r_fin_q, r_prog_q;

  logic          w_prog_e, w_del_e, w_ins_e, w_fin_e;
  logic          w_in_prog;
  logic [3:0]    w_hits;
  logic [1:0]    w_tier;
  logic [DW-1:0] w_secret_init;

  // Secret parameter lists the first-entered digit most significant; flip it
  // into slot order so it lines up with the digits register.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_secret_init
    assign w_secret_init[4*gi +: 4] = SECRET_INIT[4*(N_DIGITS-1-gi) +: 4];
  end

  // Only the highest-priority edge of a cycle is acted upon.
  assign w_prog_e  = prog & ~r_prog_q;
  assign w_del_e   = del & ~r_del_q & ~w_prog_e;
  assign w_ins_e   = insert & ~r_ins_q & ~(del & ~r_del_q) & ~w_prog_e;
  assign w_fin_e   = finish & ~r_fin_q & ~(insert & ~r_ins_q) & ~(del & ~r_del_q) & ~w_prog_e;
  assign w_in_prog = (r_state == ST_PROG);

  always_comb begin
    w_hits = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_digits[4*i +: 4] == r_secret[4*i +: 4]) w_hits = w_hits + 4'd1;
    end
    w_tier = 2'd0;
    if (w_hits == N_CNT) w_tier = 2'd3;
    else if (w_hits == N_CNT - 4'd1) w_tier = 2'd2;
    else if ((r_digits[DW-1 -: 4] == r_secret[DW-1 -: 4]) && (w_hits >= N_CNT - 4'd2)) w_tier = 2'd1;
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_digits_next = r_digits;
    w_shadow_next = r_shadow;
    w_secret_next = r_secret;
    w_prize_next  = r_prize;
    w_win_next    = r_win;
    w_err_next    = 1'b0;
    w_hold_next   = r_hold;
    case (r_state)
      ST_ENTRY, ST_PROG: begin
        if (w_prog_e) begin
          if (r_count == 4'd0) begin
            w_state_next  = ST_PROG;
            w_shadow_next = '0;
          end else begin
            w_err_next = 1'b1;
          end
        end else if (w_del_e) begin
          if (r_count != 4'd0) begin
            w_count_next = r_count - 4'd1;
            for (int i = 0; i < N_DIGITS; i++) begin
              if (4'(i) == w_count_next) begin
                if (w_in_prog) w_shadow_next[4*i +: 4] = 4'd0;
                else           w_digits_next[4*i +: 4] = 4'd0;
              end
            end
          end else if (w_in_prog) begin
            w_state_next = ST_ENTRY;
          end else begin
            w_err_next = 1'b1;
          end
        end else if (w_ins_e) begin
          if (num > 4'd9) begin
            w_err_next = 1'b1;
          end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (4'(i) == r_count) begin
                if (w_in_prog) w_shadow_next[4*i +: 4] = num;
                else           w_digits_next[4*i +: 4] = num;
              end
            end
            if (r_count == N_CNT - 4'd1) begin
              if (w_in_prog) begin
                w_secret_next = w_shadow_next;
                w_count_next  = 4'd0;
                w_state_next  = ST_ENTRY;
              end else begin
                w_count_next = N_CNT;
                w_state_next = ST_READY;
              end
            end else begin
              w_count_next = r_count + 4'd1;
            end
          end
        end else if (w_fin_e) begin
          w_err_next = 1'b1;
        end
      end
      ST_READY: begin
        if (w_del_e) begin
          w_count_next = r_count - 4'd1;
          w_digits_next[DW-1 -: 4] = 4'd0;
          w_state_next = ST_ENTRY;
        end else if (w_ins_e) begin
          w_err_next = 1'b1;
        end else if (w_fin_e) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_prize_next = w_tier;
        w_win_next   = (w_tier != 2'd0);
        w_hold_next  = 32'd0;
        w_state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if (w_fin_e || ((HOLD_CYCLES != 0) && (r_hold == HOLD_LAST))) begin
          w_count_next  = 4'd0;
          w_digits_next = '0;
          w_prize_next  = 2'd0;
          w_win_next    = 1'b0;
          w_state_next  = ST_ENTRY;
        end else if (HOLD_CYCLES != 0) begin
          w_hold_next = r_hold + 32'd1;
        end
      end
      default: w_state_next = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_ENTRY;
      r_count  <= 4'd0;
      r_digits <= '0;
      r_shadow <= '0;
      r_secret <= w_secret_init;
      r_prize  <= 2'd0;
      r_win    <= 1'b0;
      r_err    <= 1'b0;
      r_hold   <= 32'd0;
      r_ins_q  <= 1'b0;
      r_del_q  <= 1'b0;
      r_fin_q  <= 1'b0;
      r_prog_q <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_digits <= w_digits_next;
      r_shadow <= w_shadow_next;
      r_secret <= w_secret_next;
      r_prize  <= w_prize_next;
      r_win    <= w_win_next;
      r_err    <= w_err_next;
      r_hold   <= w_hold_next;
      r_ins_q  <= insert;
      r_del_q  <= del;
      r_fin_q  <= finish;
      r_prog_q <= prog;
    end
  end

  // Active-low segments {g,f,e,d,c,b,a}; empty slots and program mode show a dash.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_hex
    logic [6:0] w_seg;
    always_comb begin
      case (r_digits[4*gi +: 4])
        4'd0:    w_seg = 7'b1000000;
        4'd1:    w_seg = 7'b1111001;
        4'd2:    w_seg = 7'b0100100;
        4'd3:    w_seg = 7'b0110000;
        4'd4:    w_seg = 7'b0011001;
        4'd5:    w_seg = 7'b0010010;
        4'd6:    w_seg = 7'b0000010;
        4'd7:    w_seg = 7'b1111000;
        4'd8:    w_seg = 7'b0000000;
        4'd9:    w_seg = 7'b0010000;
        default: w_seg = 7'b0111111;
      endcase
    end
    assign hex[7*gi +: 7] = (w_in_prog || (4'(gi) >= r_count)) ? 7'b0111111 : w_seg;
  end

  assign state  = r_state;
  assign count  = r_count;
  assign digits = r_digits;
  assign prize  = r_prize;
  assign win    = r_win;
  assign err    = r_err;

endmodule

// File: tb/tb_loteria_param.sv
// Directed bench for loteria_param: a default 5-digit instance and a 3-digit
// instance with auto-return, driven from shared inputs with separate resets.
module tb_loteria_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] num;
  logic       insert, del, finish, prog;

  logic [2:0]  a_state, b_state;
  logic [3:0]  a_count, b_count;
  logic [19:0] a_digits;
  logic [11:0] b_digits;
  logic [34:0] a_hex;
  logic [20:0] b_hex;
  logic [1:0]  a_prize, b_prize;
  logic        a_win, b_win, a_err, b_err;

  int n_checks = 0;
  int n_errors = 0;

  loteria_param #(.N_DIGITS(5), .SECRET_INIT(32'h0005_0967), .HOLD_CYCLES(0)) u_a (
    .clk(clk), .reset(rst_a), .num(num), .insert(insert), .del(del), .finish(finish),
    .prog(prog), .state(a_state), .count(a_count), .digits(a_digits), .hex(a_hex),
    .prize(a_prize), .win(a_win), .err(a_err)
  );

  loteria_param #(.N_DIGITS(3), .SECRET_INIT(32'h0005_0967), .HOLD_CYCLES(4)) u_b (
    .clk(clk), .reset(rst_b), .num(num), .insert(insert), .del(del), .finish(finish),
    .prog(prog), .state(b_state), .count(b_count), .digits(b_digits), .hex(b_hex),
    .prize(b_prize), .win(b_win), .err(b_err)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 insert, 1 del, 2 finish, 3 prog; one edge then release
  task automatic press(input int which);
    case (which)
      0: insert = 1'b1;
      1: del    = 1'b1;
      2: finish = 1'b1;
      default: prog = 1'b1;
    endcase
    tick();
    insert = 1'b0; del = 1'b0; finish = 1'b0; prog = 1'b0;
    tick();
  endtask

  task automatic ins(input logic [3:0] d);
    num = d;
    press(0);
  endtask

  // v holds the ticket first-entered digit most significant
  task automatic enter5(input logic [19:0] v);
    for (int i = 0; i < 5; i++) ins(v[4*(4-i) +: 4]);
  endtask

  task automatic enter3(input logic [11:0] v);
    for (int i = 0; i < 3; i++) ins(v[4*(2-i) +: 4]);
  endtask

  task automatic play_a(input string tag, input logic [19:0] v, input logic [1:0] exp_prize);
    enter5(v);
    check_val({tag, " ready"}, 64'(a_state), 64'd1);
    press(2);
    check_val({tag, " result"}, 64'(a_state), 64'd3);
    check_val({tag, " prize"}, 64'(a_prize), 64'(exp_prize));
    check_val({tag, " win"}, 64'(a_win), 64'(exp_prize != 2'd0));
    press(2);
    check_val({tag, " back"}, 64'(a_state), 64'd0);
  endtask

  logic [34:0] dash5;
  logic [34:0] hex_50967;
  int n_res;

  initial begin
    num = 4'd0; insert = 1'b0; del = 1'b0; finish = 1'b0; prog = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    dash5     = {5{7'b0111111}};
    hex_50967 = {7'b1111000, 7'b0000010, 7'b0010000, 7'b1000000, 7'b0010010};
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    check_val("rst state", 64'(a_state), 64'd0);
    check_val("rst count", 64'(a_count), 64'd0);
    check_val("rst digits", 64'(a_digits), 64'd0);
    check_val("rst prize", 64'(a_prize), 64'd0);
    check_val("rst win", 64'(a_win), 64'd0);
    check_val("rst err", 64'(a_err), 64'd0);
    check_val("rst hex", 64'(a_hex), 64'(dash5));

    // Jackpot with the default secret, walking through every state
    ins(4'd5); ins(4'd0); ins(4'd9); ins(4'd6);
    check_val("g1 count4", 64'(a_count), 64'd4);
    check_val("g1 entry", 64'(a_state), 64'd0);
    ins(4'd7);
    check_val("g1 ready", 64'(a_state), 64'd1);
    finish = 1'b1; tick();
    check_val("g1 check", 64'(a_state), 64'd2);
    finish = 1'b0; tick();
    check_val("g1 result", 64'(a_state), 64'd3);
    check_val("g1 prize", 64'(a_prize), 64'd3);
    check_val("g1 win", 64'(a_win), 64'd1);
    check_val("g1 digits", 64'(a_digits), 64'h76905);
    check_val("g1 hex", 64'(a_hex), 64'(hex_50967));
    press(2);
    check_val("g1 new state", 64'(a_state), 64'd0);
    check_val("g1 new count", 64'(a_count), 64'd0);
    check_val("g1 new digits", 64'(a_digits), 64'd0);
    check_val("g1 new prize", 64'(a_prize), 64'd0);

    play_a("medium", 20'h50961, 2'd2);
    play_a("small", 20'h50127, 2'd1);
    play_a("none", 20'h12347, 2'd0);

    // Delete handling and rejected actions
    ins(4'd5); ins(4'd0); ins(4'd9);
    press(1); press(1);
    ins(4'd0);
    check_val("del count", 64'(a_count), 64'd2);
    check_val("del digits", 64'(a_digits), 64'h00005);
    num = 4'd12; insert = 1'b1; tick();
    check_val("bad digit err", 64'(a_err), 64'd1);
    check_val("bad digit count", 64'(a_count), 64'd2);
    insert = 1'b0; tick();
    check_val("err one cycle", 64'(a_err), 64'd0);
    press(1); press(1);
    del = 1'b1; tick();
    check_val("del empty err", 64'(a_err), 64'd1);
    del = 1'b0; tick();
    finish = 1'b1; tick();
    check_val("finish early err", 64'(a_err), 64'd1);
    check_val("finish early state", 64'(a_state), 64'd0);
    finish = 1'b0; tick();

    // Level held for 10 cycles stores one digit; insert+del together only deletes
    num = 4'd3; insert = 1'b1;
    repeat (10) tick();
    insert = 1'b0; tick();
    check_val("held insert count", 64'(a_count), 64'd1);
    check_val("held insert digits", 64'(a_digits), 64'h00003);
    num = 4'd4; insert = 1'b1; del = 1'b1; tick();
    check_val("ins+del count", 64'(a_count), 64'd0);
    check_val("ins+del digits", 64'(a_digits), 64'd0);
    check_val("ins+del err", 64'(a_err), 64'd0);
    insert = 1'b0; del = 1'b0; tick();

    // Reset in mid-entry
    ins(4'd1); ins(4'd2); ins(4'd3);
    check_val("mid count", 64'(a_count), 64'd3);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check_val("mid rst state", 64'(a_state), 64'd0);
    check_val("mid rst count", 64'(a_count), 64'd0);
    check_val("mid rst digits", 64'(a_digits), 64'd0);
    tick();

    // Program a new secret, then play it
    press(3);
    check_val("prog state", 64'(a_state), 64'd4);
    ins(4'd1); ins(4'd2);
    check_val("prog hex", 64'(a_hex), 64'(dash5));
    check_val("prog count", 64'(a_count), 64'd2);
    ins(4'd3); ins(4'd4); ins(4'd5);
    check_val("prog done state", 64'(a_state), 64'd0);
    check_val("prog done count", 64'(a_count), 64'd0);
    play_a("prog jackpot", 20'h12345, 2'd3);
    play_a("prog old secret", 20'h50967, 2'd0);

    // Reset in RESULT restores the parameter secret
    enter5(20'h12345);
    press(2);
    check_val("pre-rst prize", 64'(a_prize), 64'd3);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check_val("res rst state", 64'(a_state), 64'd0);
    check_val("res rst prize", 64'(a_prize), 64'd0);
    check_val("res rst win", 64'(a_win), 64'd0);
    check_val("res rst count", 64'(a_count), 64'd0);
    tick();
    play_a("restored", 20'h50967, 2'd3);

    // Three-digit instance with a four-cycle result hold
    rst_b = 1'b1; tick(); rst_b = 1'b0; tick();
    check_val("b rst state", 64'(b_state), 64'd0);
    enter3(12'h967);
    check_val("b ready", 64'(b_state), 64'd1);
    finish = 1'b1; tick();
    check_val("b check", 64'(b_state), 64'd2);
    finish = 1'b0;
    tick();
    check_val("b prize", 64'(b_prize), 64'd3);
    check_val("b win", 64'(b_win), 64'd1);
    check_val("b hex", 64'(b_hex), 64'({7'b1111000, 7'b0000010, 7'b0010000}));
    n_res = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b_state != 3'd3) break;
      n_res++;
    end
    check_val("b hold cycles", 64'(n_res), 64'd4);
    check_val("b auto state", 64'(b_state), 64'd0);
    check_val("b auto count", 64'(b_count), 64'd0);
    check_val("b auto prize", 64'(b_prize), 64'd0);
    enter3(12'h127);
    press(2);
    check_val("b small", 64'(b_prize), 64'd1);
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    check_val("b rst result state", 64'(b_state), 64'd0);
    check_val("b rst result win", 64'(b_win), 64'd0);
    tick();
    enter3(12'h961);
    press(2);
    check_val("b medium", 64'(b_prize), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
